// File: rtl/ysyx_24080006_mdu_ctrl_pkg.sv
// Shared types for the RV32M iterative multiply/divide sequencer and its
// borrowed-ALU interface.
package ysyx_24080006_mdu_ctrl_pkg;

    localparam int MDU_ITER = 33;

    typedef enum logic [1:0] {
        MDU_MULL = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        mdu_op_e op;
        logic    signed_a;
        logic    signed_b;
    } mdu_set_t;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [33:0] res_34;
        logic [31:0] res_32;
        logic        not_zero;
    } alu2mdu_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP_A,
        PREP_B,
        LOOP,
        FIX,
        DONE
    } mdu_state_e;

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer that borrows the EX-stage adder.
// Optional MDU_EARLY_OUT_EN: multiplies by zero finish straight after PREP_B.
module ysyx_24080006_mdu_ctrl
    import ysyx_24080006_mdu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  mdu_set_t    mdu_set,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        alu_own,
    output mdu2alu_t    mdu2alu,
    input  alu2mdu_t    alu2mdu
);

    localparam int MUL_ITER = MDU_ITER;

    mdu_state_e  r_state;
    mdu_state_e  w_next;
    mdu_op_e     r_op;
    logic [32:0] r_a;
    logic [32:0] r_b;
    logic [65:0] r_prod;
    logic [5:0]  r_cnt;
    logic        r_qNeg;
    logic [31:0] r_result;
`ifdef MDU_EARLY_OUT_EN
    logic        r_aZero;
`endif

    logic        w_accept;
    logic        w_isDiv;
    logic        w_last;
    logic        w_shortcut;
    logic [32:0] w_hi;
    logic [32:0] w_lo;
    logic [33:0] w_mulSum;

    assign w_accept = (r_state == IDLE) & in_valid & mdu_set.mdu_enable & ~flush;
    assign w_isDiv  = (r_op == MDU_DIV) || (r_op == MDU_REM);
    assign w_last   = (r_cnt == 6'(MUL_ITER - 1));
    assign w_hi     = r_prod[65:33];
    assign w_lo     = r_prod[32:0];
    // The last multiply step subtracts via hi - a == ~(~hi + a), since the adder has no carry-in.
    assign w_mulSum = (w_last & w_lo[0]) ? ~alu2mdu.res_34 : alu2mdu.res_34;

`ifdef MDU_EARLY_OUT_EN
    assign w_shortcut = w_isDiv ? ~alu2mdu.not_zero : (r_aZero | ~alu2mdu.not_zero);
`else
    assign w_shortcut = w_isDiv & ~alu2mdu.not_zero;
`endif

    assign result = r_result;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_own   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_next = PREP_A;
            end
            PREP_A: begin
                alu_own = 1'b1;
                w_next  = PREP_B;
            end
            PREP_B: begin
                alu_own = 1'b1;
                w_next  = w_shortcut ? DONE : LOOP;
            end
            LOOP: begin
                alu_own = 1'b1;
                if (w_last) w_next = FIX;
            end
            FIX: begin
                alu_own = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush && (r_state != IDLE)) w_next = IDLE;
    end

    // Adder operand steering; negations use ~x + 1 or ~(x - 1) forms.
    always_comb begin
        mdu2alu = '0;
        unique case (r_state)
            PREP_A: begin
                if (w_isDiv) begin
                    mdu2alu.a = ~r_a;
                    mdu2alu.b = 33'd1;
                end else begin
                    mdu2alu.b = r_a;
                end
            end
            PREP_B: begin
                mdu2alu.a = w_isDiv ? '1 : '0;
                mdu2alu.b = r_b;
            end
            LOOP: begin
                if (w_isDiv) begin
                    mdu2alu.a = {w_hi[31:0], w_lo[32]};
                    mdu2alu.b = r_b;
                end else begin
                    mdu2alu.a = (w_last & w_lo[0]) ? ~w_hi : w_hi;
                    mdu2alu.b = w_lo[0] ? r_a : '0;
                end
            end
            FIX: begin
                if (w_isDiv) begin
                    mdu2alu.a = ~((r_op == MDU_REM) ? w_hi : w_lo);
                    mdu2alu.b = 33'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= MDU_MULL;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_qNeg   <= 1'b0;
            r_result <= '0;
`ifdef MDU_EARLY_OUT_EN
            r_aZero  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= mdu_set.op;
                        r_a    <= {mdu_set.signed_a & rs1_data[31], rs1_data};
                        r_b    <= {mdu_set.signed_b & rs2_data[31], rs2_data};
                        r_qNeg <= (mdu_set.signed_a & rs1_data[31]) ^ (mdu_set.signed_b & rs2_data[31]);
                        r_cnt  <= '0;
                    end
                end
                PREP_A: begin
                    // Division keeps the original a for the divide-by-zero remainder.
                    if (w_isDiv)
                        r_prod <= {33'd0, r_a[32] ? alu2mdu.res_34[32:0] : r_a};
                    else
                        r_prod <= {33'd0, r_b};
`ifdef MDU_EARLY_OUT_EN
                    r_aZero <= ~alu2mdu.not_zero;
`endif
                end
                PREP_B: begin
                    if (w_isDiv)
                        r_b <= r_b[32] ? r_b : ~alu2mdu.res_34[32:0];
                    if (w_shortcut) begin
                        unique case (r_op)
                            MDU_DIV: r_result <= '1;
                            MDU_REM: r_result <= r_a[31:0];
                            default: r_result <= '0;
                        endcase
                    end
                end
                LOOP: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_isDiv) begin
                        if (!alu2mdu.res_34[33])
                            r_prod <= {alu2mdu.res_34[32:0], w_lo[31:0], 1'b1};
                        else
                            r_prod <= {w_hi[31:0], w_lo, 1'b0};
                    end else begin
                        r_prod <= {w_mulSum, w_lo[32:1]};
                    end
                end
                FIX: begin
                    unique case (r_op)
                        MDU_MULL: r_result <= r_prod[31:0];
                        MDU_MULH: r_result <= r_prod[63:32];
                        MDU_DIV:  r_result <= r_qNeg ? alu2mdu.res_32 : w_lo[31:0];
                        default:  r_result <= r_a[32] ? alu2mdu.res_32 : w_hi[31:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Self-checking bench for ysyx_24080006_mdu_ctrl: directed plus randomized ops
// against an arithmetic reference model; also covers flush and mid-op reset.
module tb_ysyx_24080006_mdu_ctrl;
    import ysyx_24080006_mdu_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    mdu_set_t    mdu_set;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        alu_own;
    mdu2alu_t    mdu2alu;
    alu2mdu_t    alu2mdu;

    int testCount = 0;
    int failCount = 0;

    ysyx_24080006_mdu_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mdu_set  (mdu_set),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .alu_own  (alu_own),
        .mdu2alu  (mdu2alu),
        .alu2mdu  (alu2mdu)
    );

    always #5 clock = ~clock;

    // EX-stage adder seen by the sequencer.
    always_comb begin
        alu2mdu.res_34   = {mdu2alu.a[32], mdu2alu.a} + {mdu2alu.b[32], mdu2alu.b};
        alu2mdu.res_32   = alu2mdu.res_34[31:0];
        alu2mdu.not_zero = |mdu2alu.b[31:0];
    end

    function automatic logic [31:0] refModel(mdu_op_e op, logic sa, logic sb,
                                             logic [31:0] a, logic [31:0] b);
        longint x, y, r;
        x = sa ? longint'($signed(a)) : longint'(a);
        y = sb ? longint'($signed(b)) : longint'(b);
        case (op)
            MDU_MULL: begin r = x * y; return r[31:0]; end
            MDU_MULH: begin r = x * y; return r[63:32]; end
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = x / y;
                return r[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                r = x % y;
                return r[31:0];
            end
        endcase
    endfunction

    function automatic int refLat(mdu_op_e op, logic [31:0] a, logic [31:0] b);
        if ((op == MDU_DIV || op == MDU_REM) && b == 32'd0) return 3;
`ifdef MDU_EARLY_OUT_EN
        if ((op == MDU_MULL || op == MDU_MULH) && (a == 32'd0 || b == 32'd0)) return 3;
`else
        if (a == 32'hDEAD_0000 && b == 32'hDEAD_0000 && op == MDU_REM) return 37;
`endif
        return 37;
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic startOp(input mdu_op_e op, input logic sa, input logic sb,
                           input logic [31:0] a, input logic [31:0] b);
        mdu_set.mdu_enable = 1'b1;
        mdu_set.op         = op;
        mdu_set.signed_a   = sa;
        mdu_set.signed_b   = sb;
        rs1_data           = a;
        rs2_data           = b;
        in_valid           = 1'b1;
        @(posedge clock); #1;
        in_valid           = 1'b0;
        mdu_set.mdu_enable = 1'b0;
        rs1_data           = $urandom;
        rs2_data           = $urandom;
    endtask

    task automatic doOp(input mdu_op_e op, input logic sa, input logic sb,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
        logic [31:0] expRes;
        int          expLat;
        int          cycle;
        logic        busyBad;
        logic        holdBad;
        expRes    = refModel(op, sa, sb, a, b);
        expLat    = refLat(op, a, b);
        out_ready = (hold == 0);
        startOp(op, sa, sb, a, b);
        cycle   = 1;
        busyBad = 1'b0;
        while (out_valid !== 1'b1 && cycle <= 60) begin
            if (alu_own !== 1'b1 || in_ready !== 1'b0) busyBad = 1'b1;
            @(posedge clock); #1;
            cycle++;
        end
        testCount++;
        if (cycle != expLat) begin
            failCount++;
            $display("[TB] FAIL %s latency: out_valid in cycle %0d, expected cycle %0d", tag, cycle, expLat);
        end
        testCount++;
        if (busyBad || alu_own !== 1'b0 || in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s busy flags: busyBad=%0b alu_own=%b in_ready=%b in DONE, expected alu_own=1/in_ready=0 while busy and 0/0 in DONE",
                     tag, busyBad, alu_own, in_ready);
        end
        testCount++;
        if (result !== expRes) begin
            failCount++;
            $display("[TB] FAIL %s result: got %h, expected %h (a=%h b=%h)", tag, result, expRes, a, b);
        end
        holdBad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            if (out_valid !== 1'b1 || result !== expRes) holdBad = 1'b1;
        end
        if (hold > 0) begin
            testCount++;
            if (holdBad) begin
                failCount++;
                $display("[TB] FAIL %s hold: out_valid=%b result=%h, expected valid and %h held", tag, out_valid, result, expRes);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        testCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mdu2alu !== '0) begin
            failCount++;
            $display("[TB] FAIL %s handshake: out_valid=%b in_ready=%b mdu2alu=%h, expected 0/1/0", tag, out_valid, in_ready, mdu2alu);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        testCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 || mdu2alu !== '0) begin
            failCount++;
            $display("[TB] FAIL reset: in_ready=%b out_valid=%b alu_own=%b result=%h mdu2alu=%h, expected 1/0/0/0/0",
                     in_ready, out_valid, alu_own, result, mdu2alu);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mul();
        doOp(MDU_MULL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 0, "mull_7x-3");
        doOp(MDU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
        doOp(MDU_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        doOp(MDU_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    endtask

    task automatic test_div();
        doOp(MDU_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
        doOp(MDU_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "rem_-7/2");
        doOp(MDU_DIV, 1'b0, 1'b0, 32'd100, 32'd7, 0, "divu_100/7");
        doOp(MDU_REM, 1'b0, 1'b0, 32'd100, 32'd7, 0, "remu_100/7");
    endtask

    task automatic test_div_corner();
        doOp(MDU_DIV, 1'b0, 1'b0, 32'd5, 32'd0, 0, "divu_by_zero");
        doOp(MDU_REM, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 0, "rem_by_zero");
        doOp(MDU_DIV, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
        doOp(MDU_REM, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_overflow");
    endtask

    task automatic test_flush();
        logic sawValid;
        // Abort during LOOP iteration 10 (cycle 13 after accept).
        startOp(MDU_MULL, 1'b1, 1'b1, $urandom, $urandom);
        repeat (12) begin @(posedge clock); #1; end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        testCount++;
        if (in_ready !== 1'b1 || alu_own !== 1'b0 || out_valid !== 1'b0 || mdu2alu !== '0) begin
            failCount++;
            $display("[TB] FAIL flush_loop: in_ready=%b alu_own=%b out_valid=%b mdu2alu=%h, expected 1/0/0/0",
                     in_ready, alu_own, out_valid, mdu2alu);
        end
        out_ready = 1'b1;
        sawValid  = 1'b0;
        repeat (40) begin @(posedge clock); #1; if (out_valid !== 1'b0) sawValid = 1'b1; end
        testCount++;
        if (sawValid) begin
            failCount++;
            $display("[TB] FAIL flush_loop_late: out_valid seen after flush, expected none");
        end
        // Flush while the result waits in DONE.
        out_ready = 1'b0;
        startOp(MDU_DIV, 1'b0, 1'b0, 32'd100, 32'd7);
        for (int k = 0; k < 60 && out_valid !== 1'b1; k++) begin @(posedge clock); #1; end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        testCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL flush_done: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        // Requests blocked by flush or by a cleared mdu_enable.
        mdu_set.mdu_enable = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        mdu_set.mdu_enable = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        testCount++;
        if (in_ready !== 1'b1 || alu_own !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL idle_block: in_ready=%b alu_own=%b, expected 1/0", in_ready, alu_own);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        startOp(MDU_DIV, 1'b1, 1'b1, $urandom, 32'd3);
        repeat (9) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        testCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 || mdu2alu !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_mid: in_ready=%b out_valid=%b alu_own=%b result=%h mdu2alu=%h, expected 1/0/0/0/0",
                     in_ready, out_valid, alu_own, result, mdu2alu);
        end
        reset = 1'b0;
        doOp(MDU_MULL, 1'b0, 1'b0, 32'h1234, 32'h10, 0, "after_reset");
    endtask

    task automatic test_hold();
        doOp(MDU_DIV, 1'b0, 1'b0, 32'd1000, 32'd9, 5, "hold_done");
    endtask

    task automatic test_early_out();
        doOp(MDU_MULL, 1'b0, 1'b0, 32'd0, 32'h1234, 0, "mul_zero_a");
        doOp(MDU_MULH, 1'b1, 1'b1, 32'hFFFF_0000, 32'd0, 0, "mul_zero_b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            doOp(mdu_op_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pickVal(), pickVal(), 0, "random");
        end
    endtask

    initial begin
        clock    = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        mdu_set  = '0;
        rs1_data = '0;
        rs2_data = '0;
        flush    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_flush();
        test_hold();
        test_reset_mid();
        test_early_out();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
